// File: rtl/vram_pkg.sv
// Shared widths, CPU-port FSM states and read-owner tags for the VRAM arbiter.
package vram_pkg;
  localparam int ADDR_W     = 10;  // 32x32 char cells
  localparam int DATA_W     = 8;   // char code
  localparam int WBUF_DEPTH = 4;   // posted-write FIFO depth, power of two

  typedef enum logic [1:0] {C_IDLE, C_RDQ, C_RDW, C_ACK} cpu_state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_PPU, OWN_CPU} owner_t;
endpackage

// File: rtl/vram_arbiter_if.sv
// PPU fetch port, CPU bus port and VRAM macro port bundled for the arbiter.
interface vram_arbiter_if #(
  parameter int ADDR_W = vram_pkg::ADDR_W,
  parameter int DATA_W = vram_pkg::DATA_W
);
  logic              ppu_req;
  logic [ADDR_W-1:0] ppu_addr;
  logic [DATA_W-1:0] ppu_data;
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  // Arbiter side
  modport slave (
    input  ppu_req, ppu_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
    output ppu_data, cpu_ack, cpu_rdata, ram_addr, ram_we, ram_wdata
  );
  // Requesters + VRAM side
  modport master (
    output ppu_req, ppu_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
    input  ppu_data, cpu_ack, cpu_rdata, ram_addr, ram_we, ram_wdata
  );
endinterface

// File: rtl/vram_wbuf.sv
// Posted-write FIFO holding {addr,data}; push/pop may coincide.
module vram_wbuf
  import vram_pkg::*;
#(
  parameter int W     = ADDR_W + DATA_W,
  parameter int DEPTH = WBUF_DEPTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_din,
  input  logic         i_pop,
  output logic         o_full,
  output logic         o_empty,
  output logic [W-1:0] o_head
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0][W-1:0] r_mem;
  logic [PW-1:0]           r_wp, r_rp;
  logic [CW-1:0]           r_cnt;
  logic                    w_push, w_pop;

  assign o_full  = (r_cnt == CW'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_head  = r_mem[r_rp];

  // Storage is not reset: stale entries are never visible once the count is zero
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= i_din;
  end

  // Pointers wrap naturally (DEPTH is a power of two); count tracks occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + PW'(1);
      if (w_pop)  r_rp <= r_rp + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: PPU reads fixed-latency top priority, CPU writes
// posted through vram_wbuf, CPU reads via req/ack once the write buffer is empty.
module vram_arbiter #(
  parameter int ADDR_W     = vram_pkg::ADDR_W,
  parameter int DATA_W     = vram_pkg::DATA_W,
  parameter int WBUF_DEPTH = vram_pkg::WBUF_DEPTH
) (
  input  logic          CLOCK,
  input  logic          RESET_N,
  vram_arbiter_if.slave bus
);
  import vram_pkg::*;

  cpu_state_t          r_state, w_state_nxt;
  owner_t              r_own_pipe [2];
  logic [ADDR_W-1:0]   r_ram_addr;
  logic                r_ram_we;
  logic [DATA_W-1:0]   r_ram_wdata, r_ppu_data, r_cpu_rdata;
  logic                w_full, w_empty, w_push, w_pop;
  logic                w_gnt_ppu, w_gnt_wr, w_gnt_rd, w_cpu_ack;
  logic [ADDR_W+DATA_W-1:0] w_head;

  // One access per cycle: PPU, then oldest posted write, then queued CPU read.
  // CPU reads wait for an empty buffer so read-after-write sees the new value.
  assign w_gnt_ppu = bus.ppu_req;
  assign w_gnt_wr  = !bus.ppu_req && !w_empty;
  assign w_gnt_rd  = !bus.ppu_req && w_empty && (r_state == C_RDQ);
  assign w_pop     = w_gnt_wr;
  assign w_push    = (r_state == C_IDLE) && bus.cpu_req && bus.cpu_we && !w_full;

  vram_wbuf #(.W(ADDR_W + DATA_W), .DEPTH(WBUF_DEPTH)) u_wbuf (
    .clk    (CLOCK),
    .rst_n  (RESET_N),
    .i_push (w_push),
    .i_din  ({bus.cpu_addr, bus.cpu_wdata}),
    .i_pop  (w_pop),
    .o_full (w_full),
    .o_empty(w_empty),
    .o_head (w_head)
  );

  // CPU FSM state register
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) r_state <= C_IDLE;
    else          r_state <= w_state_nxt;
  end

  // CPU FSM next state; C_RDW holds until the CPU-tagged read data returns
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      C_IDLE: if (bus.cpu_req) begin
                if (!bus.cpu_we)  w_state_nxt = C_RDQ;
                else if (!w_full) w_state_nxt = C_ACK;
              end
      C_RDQ:  if (w_gnt_rd) w_state_nxt = C_RDW;
      C_RDW:  if (r_own_pipe[1] == OWN_CPU) w_state_nxt = C_ACK;
      C_ACK:  w_state_nxt = C_IDLE;
      default: w_state_nxt = C_IDLE;
    endcase
  end

  // CPU FSM outputs: single-cycle ack while in C_ACK
  always_comb begin
    w_cpu_ack = (r_state == C_ACK);
  end

  // RAM port registers and read-owner tag launched alongside each read
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_ram_addr    <= '0;
      r_ram_we      <= 1'b0;
      r_ram_wdata   <= '0;
      r_own_pipe[0] <= OWN_NONE;
      r_own_pipe[1] <= OWN_NONE;
    end else begin
      r_ram_we      <= 1'b0;
      r_own_pipe[0] <= OWN_NONE;
      r_own_pipe[1] <= r_own_pipe[0];
      if (w_gnt_ppu) begin
        r_ram_addr    <= bus.ppu_addr;
        r_own_pipe[0] <= OWN_PPU;
      end else if (w_gnt_wr) begin
        r_ram_addr  <= w_head[ADDR_W+DATA_W-1:DATA_W];
        r_ram_wdata <= w_head[DATA_W-1:0];
        r_ram_we    <= 1'b1;
      end else if (w_gnt_rd) begin
        r_ram_addr    <= bus.cpu_addr;
        r_own_pipe[0] <= OWN_CPU;
      end
    end
  end

  // Steer returning read data to its owner; both outputs hold between reads
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_ppu_data  <= '0;
      r_cpu_rdata <= '0;
    end else begin
      if (r_own_pipe[1] == OWN_PPU) r_ppu_data  <= bus.ram_rdata;
      if (r_own_pipe[1] == OWN_CPU) r_cpu_rdata <= bus.ram_rdata;
    end
  end

  assign bus.ram_addr  = r_ram_addr;
  assign bus.ram_we    = r_ram_we;
  assign bus.ram_wdata = r_ram_wdata;
  assign bus.ppu_data  = r_ppu_data;
  assign bus.cpu_rdata = r_cpu_rdata;
  assign bus.cpu_ack   = w_cpu_ack;
endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: VRAM model, table of CPU transactions, corner-case
// sequences and a randomized PPU/CPU mix against a shadow-memory reference.
module tb_vram_arbiter;
  logic CLOCK   = 1'b0;
  logic RESET_N = 1'b0;
  always #5 CLOCK = ~CLOCK;

  vram_arbiter_if bus ();
  vram_arbiter dut (.CLOCK(CLOCK), .RESET_N(RESET_N), .bus(bus));

  int n_vec  = 0;
  int n_miss = 0;

  logic [7:0]  mem    [1024];
  logic [7:0]  shadow [1024];
  logic        ram_ready = 1'b0;
  logic [17:0] wlog   [$];
  logic [17:0] exp_wq [$];

  function automatic logic [7:0] fpat(input logic [9:0] a);
    return (a == 10'h045) ? 8'h41 : (a[7:0] ^ 8'h5A);
  endfunction

  // VRAM macro: synchronous read, write on ram_we, log every landed write
  always @(posedge CLOCK) begin
    if (!ram_ready) begin
      for (int a = 0; a < 1024; a++) mem[a] <= fpat(10'(a));
      ram_ready <= 1'b1;
    end else begin
      if (bus.ram_we) begin
        mem[bus.ram_addr] <= bus.ram_wdata;
        wlog.push_back({bus.ram_addr, bus.ram_wdata});
      end
      bus.ram_rdata <= mem[bus.ram_addr];
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic wait_ack(input int bound, output int lat, output logic [7:0] rd, output bit ok);
    lat = 0; rd = '0; ok = 1'b0;
    for (int i = 1; i <= bound; i++) begin
      tick();
      if (bus.cpu_ack) begin
        lat = i; rd = bus.cpu_rdata; ok = 1'b1;
        break;
      end
    end
    if (ok) bus.cpu_req = 1'b0;
  endtask

  task automatic cpu_op(input bit we, input logic [9:0] addr, input logic [7:0] data,
                        input int bound, output int lat, output logic [7:0] rd, output bit ok);
    bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = data;
    wait_ack(bound, lat, rd, ok);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ppu_data"},  bus.ppu_data,  0);
    chk({tag, "_cpu_ack"},   bus.cpu_ack,   0);
    chk({tag, "_cpu_rdata"}, bus.cpu_rdata, 0);
    chk({tag, "_ram_addr"},  bus.ram_addr,  0);
    chk({tag, "_ram_we"},    bus.ram_we,    0);
    chk({tag, "_ram_wdata"}, bus.ram_wdata, 0);
  endtask

  typedef struct {
    bit         we;
    logic [9:0] addr;
    logic [7:0] data;   // write data, or expected read data
    int         lat;    // cycles from request to observed ack, PPU idle
  } vec_t;

  vec_t        tbl [11];
  int          lat, cnt, bad;
  logic [7:0]  rd;
  bit          ok;
  bit          cpu_done;

  initial begin
    bus.ppu_req = 0; bus.ppu_addr = '0; bus.cpu_req = 0; bus.cpu_we = 0;
    bus.cpu_addr = '0; bus.cpu_wdata = '0;
    for (int a = 0; a < 1024; a++) shadow[a] = fpat(10'(a));

    tbl[0]  = '{1'b1, 10'h3FF, 8'hA5, 1};
    tbl[1]  = '{1'b0, 10'h3FF, 8'hA5, 4};
    tbl[2]  = '{1'b1, 10'h300, 8'h3C, 1};
    tbl[3]  = '{1'b1, 10'h301, 8'hC3, 1};
    tbl[4]  = '{1'b0, 10'h300, 8'h3C, 4};
    tbl[5]  = '{1'b0, 10'h301, 8'hC3, 4};
    tbl[6]  = '{1'b0, 10'h045, 8'h41, 4};
    tbl[7]  = '{1'b0, 10'h123, 8'h79, 4};
    tbl[8]  = '{1'b1, 10'h200, 8'hFF, 1};
    tbl[9]  = '{1'b0, 10'h200, 8'hFF, 4};
    tbl[10] = '{1'b0, 10'h3FF, 8'hA5, 4};

    // Reset state
    repeat (3) tick();
    chk_all_zero("rst");
    RESET_N = 1'b1;
    repeat (2) tick();

    // PPU fetch latency 2, data held afterwards
    bus.ppu_req = 1; bus.ppu_addr = 10'h045;
    tick();
    chk("t2_ram_addr", bus.ram_addr, 10'h045);
    chk("t2_ram_we",   bus.ram_we,   0);
    bus.ppu_req = 0;
    tick();
    chk("t2_not_early", bus.ppu_data, 0);
    tick();
    chk("t2_ppu_data", bus.ppu_data, 8'h41);
    tick();
    chk("t2_hold",     bus.ppu_data, 8'h41);

    // Table of CPU transactions with PPU idle
    for (int i = 0; i < 11; i++) begin
      cpu_op(tbl[i].we, tbl[i].addr, tbl[i].data, 12, lat, rd, ok);
      chk($sformatf("tbl%0d_lat", i), lat, tbl[i].lat);
      if (tbl[i].we) shadow[tbl[i].addr] = tbl[i].data;
      else           chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].data);
      tick();
      chk($sformatf("tbl%0d_ack_pulse", i), bus.cpu_ack, 0);
    end

    // FIFO fills under continuous PPU traffic, fifth write waits for space
    wlog.delete();
    bus.ppu_req = 1; bus.ppu_addr = 10'h000;
    for (int i = 0; i < 4; i++) begin
      cpu_op(1'b1, 10'h380 + 10'(i), 8'h10 + 8'(i), 4, lat, rd, ok);
      chk($sformatf("t4_ack%0d", i), lat, 1);
      shadow[10'h380 + 10'(i)] = 8'h10 + 8'(i);
      tick();
    end
    cpu_op(1'b1, 10'h384, 8'h14, 6, lat, rd, ok);
    chk("t4_fifth_held", ok, 0);
    chk("t4_no_drain_under_ppu", wlog.size(), 0);
    bus.ppu_req = 0;
    wait_ack(10, lat, rd, ok);
    chk("t4_fifth_acked", ok, 1);
    shadow[10'h384] = 8'h14;
    repeat (8) tick();
    chk("t4_wr_count", wlog.size(), 5);
    for (int i = 0; i < 5 && i < wlog.size(); i++)
      chk($sformatf("t4_order%0d", i), wlog[i], {10'h380 + 10'(i), 8'h10 + 8'(i)});

    // Same-edge PPU fetch and CPU read
    bus.ppu_req = 1; bus.ppu_addr = 10'h010;
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 10'h020;
    tick();                                   // edge k
    bus.ppu_req = 0;
    tick();
    chk("t5_no_ack_k1", bus.cpu_ack, 0);
    tick();
    chk("t5_ppu_data", bus.ppu_data, fpat(10'h010));
    cnt = 0;
    for (int i = 3; i <= 20; i++) begin
      tick();
      if (bus.cpu_ack) begin cnt = i; break; end
    end
    rd = bus.cpu_rdata;
    bus.cpu_req = 0;
    // ack visible after edge k+cnt is sampled by the requester at edge k+cnt+1
    chk("t5_ack_not_before_k4", (cnt + 1 >= 4), 1);
    chk("t5_cpu_rdata", rd, fpat(10'h020));
    tick();

    // Randomized PPU/CPU mix against shadow memory
    wlog.delete(); exp_wq.delete(); cpu_done = 0;
    fork
      begin : ppu_drv
        bit         pv [3];
        logic [9:0] pa [3];
        bit         dreq;
        logic [9:0] daddr;
        int         cyc;
        for (int j = 0; j < 3; j++) begin pv[j] = 0; pa[j] = '0; end
        dreq = 0; daddr = '0; cyc = 0;
        while (!cpu_done && cyc < 4000) begin
          tick(); cyc++;
          pv[2] = pv[1]; pa[2] = pa[1];
          pv[1] = pv[0]; pa[1] = pa[0];
          pv[0] = dreq;  pa[0] = daddr;
          if (pv[0]) begin
            chk("rnd_ppu_addr", bus.ram_addr, pa[0]);
            chk("rnd_ppu_we",   bus.ram_we,   0);
          end
          if (pv[2]) chk("rnd_ppu_data", bus.ppu_data, fpat(pa[2]));
          dreq  = ($urandom_range(0, 99) < 55);
          daddr = 10'($urandom_range(0, 511));
          bus.ppu_req = dreq; bus.ppu_addr = daddr;
        end
        bus.ppu_req = 0;
      end
      begin : cpu_drv
        bit         we;
        logic [9:0] a;
        logic [7:0] d;
        int         l;
        logic [7:0] r;
        bit         k;
        for (int op = 0; op < 60; op++) begin
          we = 1'($urandom_range(0, 1));
          a  = 10'h200 + 10'($urandom_range(0, 15));
          d  = 8'($urandom);
          cpu_op(we, a, d, 400, l, r, k);
          chk("rnd_ack", k, 1);
          if (!k) bus.cpu_req = 0;
          else if (we) begin
            shadow[a] = d;
            exp_wq.push_back({a, d});
          end else chk("rnd_rdata", r, shadow[a]);
          repeat ($urandom_range(0, 2)) tick();
        end
        cpu_done = 1;
      end
    join
    bus.ppu_req = 0; bus.cpu_req = 0;
    repeat (8) tick();
    chk("rnd_wr_count", wlog.size(), exp_wq.size());
    bad = 0;
    for (int i = 0; i < wlog.size() && i < exp_wq.size(); i++)
      if (wlog[i] !== exp_wq[i]) bad++;
    chk("rnd_wr_order", bad, 0);
    bad = 0;
    for (int a = 0; a < 1024; a++) if (mem[a] !== shadow[a]) bad++;
    chk("rnd_mem_final", bad, 0);

    // Reset mid-traffic while a buffered write is on the RAM port
    bus.ppu_req = 1; bus.ppu_addr = 10'h045;
    cpu_op(1'b1, 10'h250, 8'h77, 4, lat, rd, ok); tick();
    cpu_op(1'b1, 10'h251, 8'h88, 4, lat, rd, ok); tick();
    bus.ppu_req = 0;
    tick();
    chk("t1_pre_we", bus.ram_we, 1);
    #2 RESET_N = 1'b0;
    #1 chk_all_zero("t1_async");
    wlog.delete();
    bus.cpu_req = 0;
    repeat (2) tick();
    RESET_N = 1'b1;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin tick(); if (bus.ram_we) cnt++; end
    chk("t1_no_we_after", cnt, 0);
    chk("t1_no_write", wlog.size(), 0);
    chk("t1_mem_250", mem[10'h250], shadow[10'h250]);

    // Three buffered writes lost across a reset pulse
    bus.ppu_req = 1; bus.ppu_addr = 10'h100;
    for (int i = 0; i < 3; i++) begin
      cpu_op(1'b1, 10'h260 + 10'(i), 8'hE0 + 8'(i), 4, lat, rd, ok);
      chk($sformatf("t6_ack%0d", i), ok, 1);
      tick();
    end
    RESET_N = 1'b0; bus.ppu_req = 0;
    wlog.delete();
    repeat (2) tick();
    RESET_N = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin tick(); if (bus.ram_we) cnt++; end
    chk("t6_no_we_after", cnt, 0);
    chk("t6_no_write", wlog.size(), 0);
    cpu_op(1'b0, 10'h260, 8'h00, 12, lat, rd, ok);
    chk("t6_read_lat", lat, 4);
    chk("t6_read_old", rd, shadow[10'h260]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
